ps2_jump_receiver: RTL and testbench
====================================

PS2_JUMP_RECEIVER -- requirements
Module: ps2_jump_receiver

Interface
REQ-001 SHALL have parameter SYSTEM_FREQ, default 100000000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, giving the maximum idle time in microseconds between PS/2 falling edges inside one frame.
REQ-003 SHALL have parameter FILTER_LEN, default 8, giving the number of consecutive equal clk samples required to accept a new ps2_clk level.
REQ-004 SHALL have parameter JUMP_CODE, default 8'h29 (space key), giving the make code that triggers a jump.
REQ-005 SHALL have port clk, input, 1 bit: 100 MHz system clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have port ps2_clk, input, 1 bit: keyboard clock; the block never drives it.
REQ-008 SHALL have port ps2_data, input, 1 bit: keyboard data; the block never drives it.
REQ-009 SHALL have port scan_code, output, 8 bits: last accepted data byte.
REQ-010 SHALL have port scan_valid, output, 1 bit: one-cycle pulse when scan_code is updated.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is discarded.
REQ-012 SHALL have port jump, output, 1 bit: one-cycle pulse on a fresh press of JUMP_CODE.
REQ-013 SHALL have port jump_held, output, 1 bit: level, high between the make and the break of JUMP_CODE.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through two-flop synchronizers.
REQ-015 SHALL change the filtered ps2_clk level only after FILTER_LEN consecutive equal synchronized samples.
REQ-016 SHALL generate a one-cycle fall strobe on each 1->0 transition of filtered ps2_clk, and sample synchronized ps2_data on that cycle.
REQ-017 SHALL implement the FSM states IDLE, DATA, PARITY and STOP.
REQ-018 IDLE -> DATA on a strobe with data=0 (start bit); a strobe with data=1 in IDLE SHALL be ignored.
REQ-019 DATA SHALL shift 8 bits LSB first using a 3-bit counter, then move to PARITY.
REQ-020 PARITY SHALL capture the parity bit and move to STOP.
REQ-021 On the STOP strobe with data=1 and the frame valid: scan_code SHALL update and scan_valid SHALL pulse on the next clk, then the FSM returns to IDLE.
REQ-022 On the STOP strobe with data=0: the frame SHALL be dropped, frame_err SHALL pulse, and the FSM returns to IDLE.
REQ-023 A timeout counter sized as SYSTEM_FREQ/1000000*TIMEOUT_US cycles SHALL clear on every strobe and count in all non-IDLE states.
REQ-024 On timeout expiry the FSM SHALL go to IDLE, frame_err SHALL pulse, and partial data SHALL be discarded without altering scan_code.
REQ-025 Accepted byte 8'hF0 SHALL set a break flag; 8'hE0 SHALL set an extended flag; neither SHALL itself cause jump.
REQ-026 An accepted byte other than F0/E0 SHALL clear both flags after being interpreted with them.
REQ-027 A non-extended, non-break JUMP_CODE SHALL pulse jump in the same cycle as scan_valid, only if jump_held=0, and SHALL set jump_held.
REQ-028 Typematic repeats of JUMP_CODE while jump_held=1 SHALL produce scan_valid but no jump.
REQ-029 A non-extended break of JUMP_CODE SHALL clear jump_held; an extended (E0-prefixed) JUMP_CODE SHALL be ignored for jump purposes.
REQ-030 scan_valid, frame_err and jump SHALL never be high for more than one consecutive cycle.

Reset
REQ-031 While reset=0: FSM=IDLE, all counters, flags and synchronizers cleared (filtered ps2_clk=1, synchronized ps2_data=1), scan_code=8'h00, scan_valid=frame_err=jump=jump_held=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without any pulse; after release, reception SHALL restart only on the next start bit.

Configuration
REQ-033 With PS2_PARITY_CHECK_EN defined, a frame whose 9 bits (data plus parity) do not have odd parity SHALL be dropped with a frame_err pulse and no scan_valid.
REQ-034 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Reset; send frame 0x29 with correct parity at a 12.5 kHz ps2_clk -> scan_code=8'h29, scan_valid pulses once, jump pulses once, jump_held=1.
REQ-036 Send 0x29, 0x29, 0x29, then F0 and 0x29 -> jump pulses exactly once, scan_valid pulses 5 times, jump_held returns to 0 after the final byte.
REQ-037 Send E0 then 0x29 -> scan_valid pulses twice, jump stays 0, jump_held stays 0.
REQ-038 Stop ps2_clk after 4 data bits for 2.5 ms -> frame_err pulses once, scan_code is unchanged; a following 0x1C frame is received correctly.
REQ-039 With PS2_PARITY_CHECK_EN defined, send 0x29 with a flipped parity bit -> frame_err pulses, no scan_valid; without the macro -> scan_valid pulses and scan_code=8'h29.
REQ-040 Inject 3-cycle glitches on ps2_clk, and separately assert reset mid-frame -> no spurious strobes, no pulses, all outputs at their reset values.

Source files
------------

// File: rtl/ps2_jump_receiver.sv
// ps2_jump_receiver
//   PS/2 keyboard receiver that decodes frames into scan codes and turns a
//   chosen make code (space bar by default) into a one-shot jump pulse plus
//   a "held" level.
//
// Parameters
//   SYSTEM_FREQ : clk frequency in Hz
//   TIMEOUT_US  : max idle time between ps2_clk falling edges inside a frame
//   FILTER_LEN  : consecutive equal samples needed to accept a new ps2_clk level
//   JUMP_CODE   : make code that triggers a jump
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   ps2_clk    : keyboard clock (input only)
//   ps2_data   : keyboard data (input only)
//   scan_code  : last accepted data byte
//   scan_valid : one-cycle pulse when scan_code updates
//   frame_err  : one-cycle pulse when a frame is discarded
//   jump       : one-cycle pulse on a fresh press of JUMP_CODE
//   jump_held  : high between make and break of JUMP_CODE
//
// Build option
//   PS2_PARITY_CHECK_EN : when defined, frames without odd parity are dropped.
module ps2_jump_receiver #(
  parameter int          SYSTEM_FREQ = 100000000,
  parameter int          TIMEOUT_US  = 2000,
  parameter int          FILTER_LEN  = 8,
  parameter logic [7:0]  JUMP_CODE   = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       jump,
  output logic       jump_held
);

  localparam int TIMEOUT_CYCLES = SYSTEM_FREQ / 1000000 * TIMEOUT_US;
  localparam int TOW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCW            = $clog2(FILTER_LEN + 1);
  localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e         state_q, state_d;
  logic [1:0]     clkSync_q, dataSync_q;
  logic [FCW-1:0] filtCnt_q;
  logic           filtClk_q, filtClkDly_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic [TOW-1:0] toCnt_q;
  logic [7:0]     scanCode_q;
  logic           scanValid_q, frameErr_q, jump_q, jumpHeld_q;
  logic           brk_q, ext_q;
  logic           fall, dataBit, timeout, parityOk;
  logic           frameOk, frameBad, jumpMake, jumpBreak, plainByte;

  assign dataBit = dataSync_q[1];
  // Falling edge of the filtered clock, one cycle after the filter flips.
  assign fall    = filtClkDly_q & ~filtClk_q;
  // A falling edge arriving on the expiry cycle wins over the timeout.
  assign timeout = (state_q != IDLE) && (toCnt_q == TO_MAX) && !fall;

  // Input synchronizers; idle PS/2 lines are high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
    end
  end

  // Glitch filter: the level changes only after FILTER_LEN consecutive
  // samples disagree with the current filtered level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filtCnt_q    <= '0;
      filtClk_q    <= 1'b1;
      filtClkDly_q <= 1'b1;
    end else begin
      filtClkDly_q <= filtClk_q;
      if (clkSync_q[1] == filtClk_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FILT_MAX) begin
        filtClk_q <= clkSync_q[1];
        filtCnt_q <= '0;
      end else begin
        filtCnt_q <= filtCnt_q + FCW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dataBit) state_d = DATA;
        DATA:    if (bitCnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          parity_q <= 1'b0;
    else if (fall && state_q == PARITY)  parity_q <= dataBit;
  end
  assign parityOk = ^{shift_q, parity_q};
`else
  assign parityOk = 1'b1;
`endif

  // FSM output decode: frame accept/drop and key interpretation.
  always_comb begin
    frameOk   = fall && (state_q == STOP) && dataBit && parityOk;
    frameBad  = timeout || (fall && (state_q == STOP) && !(dataBit && parityOk));
    plainByte = (shift_q != 8'hF0) && (shift_q != 8'hE0);
    jumpMake  = frameOk && plainByte && (shift_q == JUMP_CODE) && !ext_q && !brk_q;
    jumpBreak = frameOk && plainByte && (shift_q == JUMP_CODE) && !ext_q && brk_q;
  end

  // Bit shifting and the inter-edge timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCnt_q <= '0;
      shift_q  <= '0;
      toCnt_q  <= '0;
    end else begin
      if (state_q == IDLE || fall) toCnt_q <= '0;
      else                         toCnt_q <= toCnt_q + TOW'(1);
      if (state_q == IDLE) begin
        bitCnt_q <= '0;
      end else if (fall && state_q == DATA) begin
        shift_q  <= {dataBit, shift_q[7:1]};
        bitCnt_q <= bitCnt_q + 3'd1;
      end
    end
  end

  // Registered outputs and prefix flags. Flags survive F0/E0 and are
  // consumed by the next ordinary byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scanCode_q  <= 8'h00;
      scanValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      jump_q      <= 1'b0;
      jumpHeld_q  <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      scanValid_q <= frameOk;
      frameErr_q  <= frameBad;
      jump_q      <= jumpMake && !jumpHeld_q;
      if (jumpMake)  jumpHeld_q <= 1'b1;
      if (jumpBreak) jumpHeld_q <= 1'b0;
      if (frameOk) begin
        scanCode_q <= shift_q;
        if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end
      end
    end
  end

  assign scan_code  = scanCode_q;
  assign scan_valid = scanValid_q;
  assign frame_err  = frameErr_q;
  assign jump       = jump_q;
  assign jump_held  = jumpHeld_q;

endmodule

// File: tb/tb_ps2_jump_receiver.sv
// tb_ps2_jump_receiver
//   Directed bench for ps2_jump_receiver. SYSTEM_FREQ is scaled to 1 MHz so
//   the 12.5 kHz PS/2 clock is 80 system cycles per bit and the 2000 us
//   timeout is 2000 cycles, keeping the run short.
`timescale 1ns/1ps
module tb_ps2_jump_receiver;

  localparam int HALF_BIT = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err, jump, jump_held;

  int checks = 0;
  int errors = 0;
  int svCnt = 0, feCnt = 0, jmCnt = 0, dblCnt = 0;
  int svBase = 0, feBase = 0, jmBase = 0;
  logic svPrev = 1'b0, fePrev = 1'b0, jmPrev = 1'b0;
  logic [7:0] expCode;

  ps2_jump_receiver #(
    .SYSTEM_FREQ(1000000),
    .TIMEOUT_US (2000),
    .FILTER_LEN (8),
    .JUMP_CODE  (8'h29)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err),
    .jump      (jump),
    .jump_held (jump_held)
  );

  always #5 clk = ~clk;

  // Count output pulses and any pulse lasting more than one cycle.
  always @(negedge clk) begin
    if (scan_valid) svCnt++;
    if (frame_err)  feCnt++;
    if (jump)       jmCnt++;
    if ((scan_valid && svPrev) || (frame_err && fePrev) || (jump && jmPrev)) dblCnt++;
    svPrev = scan_valid;
    fePrev = frame_err;
    jmPrev = jump;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic markCounts();
    svBase = svCnt;
    feBase = feCnt;
    jmBase = jmCnt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends the first nBits bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic applyStimulus(input logic [7:0] b, input bit flipParity, input int nBits);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ flipParity, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2_data = frame[i];
      waitCycles(HALF_BIT);
      ps2_clk = 1'b0;
      waitCycles(HALF_BIT);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    waitCycles(HALF_BIT);
  endtask

  task automatic checkDeltas(input string tag, input int sv, input int fe, input int jm);
    checkOutput({tag, "_sv"}, svCnt - svBase, sv);
    checkOutput({tag, "_fe"}, feCnt - feBase, fe);
    checkOutput({tag, "_jump"}, jmCnt - jmBase, jm);
  endtask

  initial begin
    // Reset state
    waitCycles(10);
    checkOutput("rst_code", scan_code, 8'h00);
    checkOutput("rst_sv", scan_valid, 0);
    checkOutput("rst_fe", frame_err, 0);
    checkOutput("rst_jump", jump, 0);
    checkOutput("rst_held", jump_held, 0);
    reset = 1'b1;
    waitCycles(20);

    // Single space press
    markCounts();
    applyStimulus(8'h29, 0, 11);
    checkOutput("press_code", scan_code, 8'h29);
    checkDeltas("press", 1, 0, 1);
    checkOutput("press_held", jump_held, 1);

    // Typematic repeats then break: five bytes in total, one jump
    applyStimulus(8'h29, 0, 11);
    applyStimulus(8'h29, 0, 11);
    checkOutput("repeat_held", jump_held, 1);
    applyStimulus(8'hF0, 0, 11);
    checkOutput("brk_prefix_code", scan_code, 8'hF0);
    checkOutput("brk_prefix_held", jump_held, 1);
    applyStimulus(8'h29, 0, 11);
    checkDeltas("typematic", 5, 0, 1);
    checkOutput("release_held", jump_held, 0);

    // Extended code is ignored for jump purposes
    markCounts();
    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'h29, 0, 11);
    checkDeltas("ext", 2, 0, 0);
    checkOutput("ext_held", jump_held, 0);

    // Stalled frame after 4 data bits times out
    markCounts();
    applyStimulus(8'h55, 0, 5);
    waitCycles(2500);
    checkDeltas("timeout", 0, 1, 0);
    checkOutput("timeout_code", scan_code, 8'h29);
    markCounts();
    applyStimulus(8'h1C, 0, 11);
    checkOutput("after_to_code", scan_code, 8'h1C);
    checkDeltas("after_to", 1, 0, 0);

    // Flipped parity bit
    markCounts();
    applyStimulus(8'h29, 1, 11);
`ifdef PS2_PARITY_CHECK_EN
    checkDeltas("badpar", 0, 1, 0);
    checkOutput("badpar_code", scan_code, 8'h1C);
    expCode = 8'h1C;
`else
    checkDeltas("badpar", 1, 0, 1);
    checkOutput("badpar_code", scan_code, 8'h29);
    expCode = 8'h29;
`endif

    // Short glitches with data low must not start a frame
    markCounts();
    ps2_data = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      waitCycles(3);
      ps2_clk = 1'b1;
      waitCycles(20);
    end
    ps2_data = 1'b1;
    waitCycles(2500);
    checkDeltas("glitch", 0, 0, 0);
    checkOutput("glitch_code", scan_code, expCode);

    // Reset in the middle of a frame
    applyStimulus(8'h29, 0, 6);
    markCounts();
    reset = 1'b0;
    waitCycles(20);
    checkOutput("midrst_code", scan_code, 8'h00);
    checkOutput("midrst_held", jump_held, 0);
    checkOutput("midrst_lvl", {29'd0, scan_valid, frame_err, jump}, 0);
    reset = 1'b1;
    waitCycles(2500);
    checkDeltas("midrst", 0, 0, 0);
    applyStimulus(8'h29, 0, 11);
    checkOutput("post_rst_code", scan_code, 8'h29);
    checkDeltas("post_rst", 1, 0, 1);
    checkOutput("post_rst_held", jump_held, 1);

    checkOutput("single_cycle_pulses", dblCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
